// File: rtl/id_exe_pipe_reg.sv
`default_nettype none
// id_exe_pipe_reg: decode-to-execute pipeline register with freeze, flush/hazard bubbles
// and a saturating bubble counter.  Rev 1.0
module id_exe_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              hazard,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic              imm_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm24_in,
  input  logic [3:0]        dest_in,
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  input  logic [3:0]        sr_in,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic              b_out,
  output logic              s_out,
  output logic [3:0]        exe_cmd_out,
  output logic              imm_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] val_rn_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm24_out,
  output logic [3:0]        dest_out,
  output logic [3:0]        src1_out,
  output logic [3:0]        src2_out,
  output logic [3:0]        sr_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic bubble;
  assign bubble = flush | hazard;

  always_ff @(posedge clk) begin
    if (rst || (!freeze && bubble)) begin
      // A bubble clears the data fields too, so src1/src2 can never match a stale forward.
      wb_en_out         <= 1'b0;
      mem_r_en_out      <= 1'b0;
      mem_w_en_out      <= 1'b0;
      b_out             <= 1'b0;
      s_out             <= 1'b0;
      exe_cmd_out       <= 4'd0;
      imm_out           <= 1'b0;
      pc_out            <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      shift_operand_out <= 12'd0;
      signed_imm24_out  <= 24'd0;
      dest_out          <= 4'd0;
      src1_out          <= 4'd0;
      src2_out          <= 4'd0;
      sr_out            <= 4'd0;
      valid_out         <= 1'b0;
    end else if (!freeze) begin
      wb_en_out         <= wb_en_in;
      mem_r_en_out      <= mem_r_en_in;
      mem_w_en_out      <= mem_w_en_in;
      b_out             <= b_in;
      s_out             <= s_in;
      exe_cmd_out       <= exe_cmd_in;
      imm_out           <= imm_in;
      pc_out            <= pc_in;
      val_rn_out        <= val_rn_in;
      val_rm_out        <= val_rm_in;
      shift_operand_out <= shift_operand_in;
      signed_imm24_out  <= signed_imm24_in;
      dest_out          <= dest_in;
      src1_out          <= src1_in;
      src2_out          <= src2_in;
      sr_out            <= sr_in;
      valid_out         <= 1'b1;
    end
  end

  // Flush and hazard in the same cycle are one bubble, counted once.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (!freeze && bubble && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_exe_pipe_reg.sv
`default_nettype none
// Self-checking bench for id_exe_pipe_reg: directed test-plan steps plus randomized
// cycles compared against a behavioural model of the stage register.
module tb_id_exe_pipe_reg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int PW     = 158;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, freeze, flush, hazard;
  logic wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
  logic [3:0] exe_cmd_in, dest_in, src1_in, src2_in, sr_in;
  logic [DATA_W-1:0] pc_in, val_rn_in, val_rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm24_in;

  logic wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, valid_out;
  logic [3:0] exe_cmd_out, dest_out, src1_out, src2_out, sr_out;
  logic [DATA_W-1:0] pc_out, val_rn_out, val_rm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm24_out;
  logic [CNT_W-1:0] bubble_cnt;

  id_exe_pipe_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in), .imm_in(imm_in),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .signed_imm24_in(signed_imm24_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .sr_in(sr_in),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .b_out(b_out), .s_out(s_out), .exe_cmd_out(exe_cmd_out), .imm_out(imm_out),
    .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .shift_operand_out(shift_operand_out), .signed_imm24_out(signed_imm24_out),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .sr_out(sr_out),
    .valid_out(valid_out), .bubble_cnt(bubble_cnt)
  );

  wire [PW-1:0] in_bus = {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in,
                          imm_in, pc_in, val_rn_in, val_rm_in, shift_operand_in,
                          signed_imm24_in, dest_in, src1_in, src2_in, sr_in};
  wire [PW-1:0] out_bus = {wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, exe_cmd_out,
                           imm_out, pc_out, val_rn_out, val_rm_out, shift_operand_out,
                           signed_imm24_out, dest_out, src1_out, src2_out, sr_out};

  // Reference model state: what the execute stage should be holding.
  logic [PW-1:0] m_payload;
  logic          m_valid;
  int            m_bubbles;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_inputs(input logic r, input logic fz, input logic fl, input logic hz);
    rst = r; freeze = fz; flush = fl; hazard = hz;
  endtask

  task automatic rand_data();
    {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in} = 6'($urandom);
    exe_cmd_in = 4'($urandom); dest_in = 4'($urandom);
    src1_in = 4'($urandom); src2_in = 4'($urandom); sr_in = 4'($urandom);
    pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
    shift_operand_in = 12'($urandom); signed_imm24_in = 24'($urandom);
  endtask

  // One clock: advance the model from the inputs at the edge, then compare everything.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) begin
      m_payload = '0; m_valid = 1'b0; m_bubbles = 0;
    end else if (freeze) begin
      // nothing changes
    end else if (flush || hazard) begin
      m_payload = '0; m_valid = 1'b0;
      m_bubbles = (m_bubbles + 1 > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : m_bubbles + 1;
    end else begin
      m_payload = in_bus; m_valid = 1'b1;
    end
    #1;
    chk({tag, ".payload"}, out_bus, m_payload);
    chk({tag, ".valid"}, PW'(valid_out), PW'(m_valid));
    chk({tag, ".bubble_cnt"}, PW'(bubble_cnt), PW'(m_bubbles));
    @(negedge clk);
  endtask

  initial begin
    m_payload = '0; m_valid = 1'b0; m_bubbles = 0;
    set_inputs(1'b1, 1'b0, 1'b0, 1'b0);
    rand_data();

    // Reset then first load
    pc_in = 32'h4; val_rn_in = 32'h11; val_rm_in = 32'h22; wb_en_in = 1'b1;
    exe_cmd_in = 4'h2; dest_in = 4'd3;
    tick("reset0");
    tick("reset1");
    chk("reset.all_zero", out_bus, '0);
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0);
    tick("load");
    chk("load.pc", PW'(pc_out), PW'(32'h4));
    chk("load.val_rn", PW'(val_rn_out), PW'(32'h11));
    chk("load.val_rm", PW'(val_rm_out), PW'(32'h22));
    chk("load.wb_exe_dest", PW'({wb_en_out, exe_cmd_out, dest_out}), PW'({1'b1, 4'h2, 4'd3}));

    // Freeze holds even with flush pending
    pc_in = 32'h8;
    tick("load8");
    set_inputs(1'b0, 1'b1, 1'b1, 1'b0);
    pc_in = 32'hC;
    for (int i = 0; i < 3; i++) tick("freeze");
    chk("freeze.pc", PW'(pc_out), PW'(32'h8));
    chk("freeze.cnt", PW'(bubble_cnt), PW'(0));
    set_inputs(1'b0, 1'b0, 1'b1, 1'b0);
    tick("unfreeze_flush");
    chk("unfreeze_flush.cnt", PW'(bubble_cnt), PW'(1));

    // Flush squash
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0);
    rand_data();
    tick("load_before_flush");
    mem_w_en_in = 1'b1; b_in = 1'b1; dest_in = 4'd5;
    set_inputs(1'b0, 1'b0, 1'b1, 1'b0);
    tick("flush");
    chk("flush.memw_b_dest", PW'({mem_w_en_out, b_out, dest_out}), '0);
    chk("flush.cnt", PW'(bubble_cnt), PW'(2));

    // Flush and hazard together count once
    set_inputs(1'b0, 1'b0, 1'b1, 1'b1);
    tick("flush_hazard");
    chk("flush_hazard.cnt", PW'(bubble_cnt), PW'(3));
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0);
    rand_data();
    tick("reload");

    // Saturation
    set_inputs(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) tick("hazard_sat");
    chk("sat.cnt", PW'(bubble_cnt), PW'(15));

    // Reset during freeze with bubble_cnt=7
    set_inputs(1'b1, 1'b0, 1'b0, 1'b0);
    tick("reset_again");
    set_inputs(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) tick("hazard7");
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0);
    rand_data();
    tick("load_pre_freeze");
    set_inputs(1'b0, 1'b1, 1'b0, 1'b0);
    tick("freeze7");
    chk("freeze7.cnt", PW'(bubble_cnt), PW'(7));
    set_inputs(1'b1, 1'b1, 1'b1, 1'b0);
    tick("rst_mid_freeze");
    chk("rst_mid_freeze.all", PW'({out_bus, valid_out, bubble_cnt}), '0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_data();
      set_inputs($urandom_range(0, 40) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 5) == 0);
      tick("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_exe_pipe_reg.md
Name: id_exe_pipe_reg

Overview:
- Pipeline register between the decode stage and the execute stage of the ARM core.
- Captures the two register-file read operands, decoded control fields, immediates, PC and status flags on each rising clock edge.
- Supports memory-stall freeze, branch flush and hazard bubble insertion.
- Keeps a saturating count of inserted bubbles for performance monitoring.

Parameters:
- DATA_W, 32, width of PC and operand values.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- freeze  in  1  memory stall; hold all state
- flush  in  1  taken branch in execute; squash the instruction being loaded
- hazard  in  1  data hazard detected in decode; insert a bubble
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in  in  1 each  decoded control bits
- exe_cmd_in  in  4  ALU command
- imm_in  in  1  operand-2-is-immediate flag
- pc_in  in  DATA_W  PC of the decoded instruction
- val_rn_in, val_rm_in  in  DATA_W  register-file read data (reg1, reg2)
- shift_operand_in  in  12  shifter operand field
- signed_imm24_in  in  24  branch offset
- dest_in, src1_in, src2_in  in  4 each  destination and source register indices
- sr_in  in  4  NZCV status flags
- all above with _out suffix  out  same widths  registered copies
- valid_out  out  1  1 = the execute stage holds a real instruction
- bubble_cnt  out  CNT_W  saturating count of squashed or bubbled cycles

Behaviour:
- Priority on each rising edge: rst > freeze > flush > hazard > normal load.
- rst:
  - every output is 0, including valid_out and bubble_cnt.
  - Reset in the middle of a freeze or flush still clears everything on that edge.
- freeze=1 (rst=0):
  - every output holds its value, including bubble_cnt.
  - flush and hazard are ignored in that cycle. The flush source is itself stalled, so it remains asserted until the freeze ends.
- flush=1 (freeze=0):
  - wb_en, mem_r_en, mem_w_en, b and s outputs are 0.
  - exe_cmd_out = 0 and valid_out = 0.
  - Data fields (pc, val_rn, val_rm, imm, shift_operand, signed_imm24, dest, src1, src2, sr) are also cleared to 0, so no stale forwarding match can occur.
  - bubble_cnt increments.
- hazard=1 (freeze=0, flush=0): same bubble as flush, with the same increment.
- flush and hazard together count as one bubble: bubble_cnt increments by 1, not 2.
- Normal load: every _out takes its _in value and valid_out = 1.
- Latency: exactly one cycle from input to output. There is no combinational path from any input to any output.
- bubble_cnt saturates at 2^CNT_W-1. It neither wraps nor decrements.
- src1_out and src2_out are registered copies used by the forwarding unit. A bubble zeroes them together with wb_en_out, so a bubble never produces a false forward.
- The register file writes on the falling edge. val_rn_in and val_rm_in are therefore already updated by the same-cycle writeback when this block samples them on the next rising edge; no internal bypass is needed.

Test Plan:
- Reset, then load: assert rst for 2 cycles, then drive pc_in=0x4, val_rn_in=0x11, val_rm_in=0x22, wb_en_in=1, exe_cmd_in=0x2, dest_in=3 -> all outputs 0 during reset. One edge after release, pc_out=0x4, val_rn_out=0x11, val_rm_out=0x22, wb_en_out=1, exe_cmd_out=0x2, dest_out=3, valid_out=1.
- Freeze hold: load pc_in=0x8, then freeze=1 for 3 cycles while pc_in=0xC and flush=1 -> pc_out stays 0x8, valid_out=1, bubble_cnt unchanged. One cycle after freeze drops with flush still 1, valid_out=0 and bubble_cnt=1.
- Flush squash: mem_w_en_in=1, b_in=1, dest_in=5 with flush=1 -> mem_w_en_out=0, b_out=0, dest_out=0, valid_out=0, bubble_cnt increments by 1.
- Flush and hazard together: flush=1 and hazard=1 for 1 cycle -> single bubble, bubble_cnt increments by exactly 1. Next normal load restores valid_out=1.
- Counter saturation (CNT_W=4): hold hazard=1 for 20 cycles -> bubble_cnt reaches 15 and stays at 15.
- Reset mid-freeze: freeze=1 with loaded data and bubble_cnt=7, then pulse rst -> all outputs 0 and bubble_cnt=0 on that edge.
